// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch queue: streams sequential ROM words into a FIFO
// and hands them to the core over valid/ready, flushing on redirect.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

  typedef logic [AW-1:0] ptr_t;

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [CW-1:0] count;
  ptr_t        head;
  ptr_t        tail;
  logic [31:0] mem_data [DEPTH];
  logic [31:0] mem_pc   [DEPTH];

  logic        pop;
  logic        push;
  logic        issue;
  logic [CW:0] occ;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop  = instr_valid & instr_ready & ~redirect;
  assign push = inflight & ~redirect;

  // Credit: queued + in-flight words after this cycle's pop must leave room.
  assign occ = {1'b0, count}
             + {{CW{1'b0}}, inflight}
             - {{CW{1'b0}}, pop};

  assign issue = reset & ~redirect & (occ < DEPTH_C);

  assign rom_req     = issue;
  assign rom_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_data  = mem_data[head];
  assign instr_pc    = mem_pc[head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (push) begin
      mem_data[tail] <= rom_data;
      mem_pc[tail]   <= inflight_pc;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && count == FULL_C)
  );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: cycle table for startup and stall,
// plus a pop scoreboard for redirect, wrap and async reset sequences.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int checks = 0;
  int failures = 0;
  bit sb_on = 1'b0;
  logic [31:0] exp_q [$];

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tv [16];

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .rom_req(rom_req),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous ROM
  always @(posedge clk)
    if (rom_req) rom_data <= rom_addr ^ KEY;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit rdy, input bit rd, input logic [31:0] rpc);
    logic [31:0] e;
    @(negedge clk);
    reset = 1'b1;
    instr_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    #1;
    if (sb_on && instr_valid && rdy && !rd) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got pc %h expected none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_data", instr_data, e ^ KEY);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) cyc(1'b1, 1'b0, '0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name,
               exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // startup streaming, ready=1
    tv[0]  = '{1, 1, 1, 32'd0,  0, 32'd0};
    tv[1]  = '{0, 1, 1, 32'd4,  0, 32'd0};
    tv[2]  = '{0, 1, 1, 32'd8,  1, 32'd0};
    tv[3]  = '{0, 1, 1, 32'd12, 1, 32'd4};
    tv[4]  = '{0, 1, 1, 32'd16, 1, 32'd8};
    tv[5]  = '{0, 1, 1, 32'd20, 1, 32'd12};
    // stalled core for 10 cycles: exactly 4 requests
    tv[6]  = '{1, 0, 1, 32'd0,  0, 32'd0};
    tv[7]  = '{0, 0, 1, 32'd4,  0, 32'd0};
    tv[8]  = '{0, 0, 1, 32'd8,  1, 32'd0};
    tv[9]  = '{0, 0, 1, 32'd12, 1, 32'd0};
    for (int i = 10; i < 16; i++) tv[i] = '{0, 0, 0, 32'd16, 1, 32'd0};

    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", instr_data, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", rom_addr, 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (tv[i].rst) do_reset();
      cyc(tv[i].rdy, 1'b0, '0);
      chk($sformatf("v%0d_req", i), 32'(rom_req), 32'(tv[i].req));
      if (tv[i].req) chk($sformatf("v%0d_addr", i), rom_addr, tv[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tv[i].valid));
      if (tv[i].valid) begin
        chk($sformatf("v%0d_pc", i), instr_pc, tv[i].pc);
        chk($sformatf("v%0d_data", i), instr_data, tv[i].pc ^ KEY);
      end
    end

    sb_on = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    drain("stall_release", 20);

    // redirect with 3 queued words and one in flight
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 32'h0000_0102);
    chk("rd3_req", 32'(rom_req), 32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("rd3_valid1", 32'(instr_valid), 32'd0);
    chk("rd3_req1", 32'(rom_req), 32'd1);
    chk("rd3_addr1", rom_addr, 32'h100);
    cyc(1'b0, 1'b0, '0);
    chk("rd3_valid2", 32'(instr_valid), 32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("rd3_valid3", 32'(instr_valid), 32'd1);
    chk("rd3_pc3", instr_pc, 32'h100);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    drain("redirect", 20);

    // redirect coinciding with a valid head and ready
    do_reset();
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h0000_0200);
    chk("rd4_head_valid", 32'(instr_valid), 32'd1);
    chk("rd4_req", 32'(rom_req), 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("rd4_valid_next", 32'(instr_valid), 32'd0);
    chk("rd4_addr", rom_addr, 32'h200);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    drain("redirect_pop", 20);

    // address wrap
    cyc(1'b1, 1'b1, 32'hFFFF_FFF8);
    cyc(1'b1, 1'b0, '0);
    chk("wrap_addr", rom_addr, 32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    drain("wrap", 20);

    // async reset mid-cycle with full FIFO
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_req", 32'(rom_req), 32'd0);
    @(posedge clk);
    #2;
    instr_ready = 1'b1;
    #1;
    chk("pre_arst_req", 32'(rom_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_req", 32'(rom_req), 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    drain("after_arst", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
